// File: rtl/elastic_decode.sv
// Elastic decoder: undoes the encoder's left shift and forwards beats through a two-entry
// skid buffer so upstream ready depends only on registered buffer state.
module elastic_decode #(
  parameter int unsigned DW    = 32,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    t0_data,
  input  logic             t0_valid,
  output logic             t0_ready,
  output logic [DW-1:0]    i0_data,
  output logic             i0_valid,
  input  logic             i0_ready,
  input  logic             err_clr,
  output logic             err_lsb,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      main_q, main_d;
  logic [DW-1:0]      skid_q, skid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      decoded;
  logic               accept;
  logic               pop;

  assign decoded  = t0_data >> SHIFT;
  assign t0_ready = (state_q != StTwo) & ~rst;
  assign i0_valid = (state_q != StEmpty);
  assign i0_data  = main_q;
  assign err_lsb  = err_q;
  assign beat_cnt = cnt_q;
  assign accept   = t0_valid & t0_ready;
  assign pop      = i0_valid & i0_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = decoded;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_d = decoded;
        end else if (accept) begin
          state_d = StTwo;
          skid_d  = decoded;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // A bad beat wins over a same-cycle clear so the violation is never lost.
  always_comb begin
    err_d = err_q;
    if (accept && (t0_data[SHIFT-1:0] != '0)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_decode.sv
// Self-checking bench for elastic_decode: directed steps then random traffic, compared
// against a queue-based model of a two-deep FIFO with a shift decode.
module tb_elastic_decode;

  localparam int unsigned DW    = 32;
  localparam int unsigned SHIFT = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SMAX  = 15;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    t0_data;
  logic             t0_valid;
  logic             t0_ready;
  logic [DW-1:0]    i0_data;
  logic             i0_valid;
  logic             i0_ready;
  logic             err_clr;
  logic             err_lsb;
  logic [CNT_W-1:0] beat_cnt;

  logic             s_t0_ready;
  logic [DW-1:0]    s_i0_data;
  logic             s_i0_valid;
  logic             s_err_lsb;
  logic [3:0]       s_beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q[$];
  logic          m_err;
  int unsigned   m_cnt;
  int unsigned   m_cnt_s;

  elastic_decode #(.DW(DW), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .t0_data  (t0_data),
    .t0_valid (t0_valid),
    .t0_ready (t0_ready),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_ready (i0_ready),
    .err_clr  (err_clr),
    .err_lsb  (err_lsb),
    .beat_cnt (beat_cnt)
  );

  // Narrow-counter copy driven by the same stream, used for saturation.
  elastic_decode #(.DW(DW), .SHIFT(SHIFT), .CNT_W(4)) dut_small (
    .clk      (clk),
    .rst      (rst),
    .t0_data  (t0_data),
    .t0_valid (t0_valid),
    .t0_ready (s_t0_ready),
    .i0_data  (s_i0_data),
    .i0_valid (s_i0_valid),
    .i0_ready (i0_ready),
    .err_clr  (err_clr),
    .err_lsb  (s_err_lsb),
    .beat_cnt (s_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs against the model, advance both.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c,
                       input logic rs);
    logic acc;
    logic pp;
    t0_valid = v;
    t0_data  = d;
    i0_ready = r;
    err_clr  = c;
    rst      = rs;
    #1;
    check("t0_ready", {31'b0, t0_ready}, {31'b0, (m_q.size() < 2) && !rs});
    check("i0_valid", {31'b0, i0_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) check("i0_data", i0_data, m_q[0]);
    check("err_lsb", {31'b0, err_lsb}, {31'b0, m_err});
    check("beat_cnt", {16'b0, beat_cnt}, m_cnt);
    check("beat_cnt_small", {28'b0, s_beat_cnt}, m_cnt_s);
    acc = v && !rs && (m_q.size() < 2);
    pp  = r && (m_q.size() != 0);
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_err   = 1'b0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end else begin
      if (pp) void'(m_q.pop_front());
      if (acc) m_q.push_back(d / (32'd1 << SHIFT));
      if (acc && (d % (32'd1 << SHIFT)) != 0) m_err = 1'b1;
      else if (c) m_err = 1'b0;
      if (acc && m_cnt < 65535) m_cnt++;
      if (acc && m_cnt_s < SMAX) m_cnt_s++;
    end
    #1;
  endtask

  initial begin
    t0_valid = 1'b0;
    t0_data  = '0;
    i0_ready = 1'b0;
    err_clr  = 1'b0;
    rst      = 1'b1;
    m_err    = 1'b0;
    m_cnt    = 0;
    m_cnt_s  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready_low", {31'b0, t0_ready}, 32'h0);

    // Reset values
    cycle(0, 0, 0, 0, 1);
    check("rst_valid", {31'b0, i0_valid}, 32'h0);
    check("rst_data", i0_data, 32'h0);
    check("rst_cnt", {16'b0, beat_cnt}, 32'h0);
    check("rst_err", {31'b0, err_lsb}, 32'h0);

    // Single beat
    cycle(1, 32'h10, 1, 0, 0);
    check("single_valid", {31'b0, i0_valid}, 32'h1);
    check("single_data", i0_data, 32'h4);
    check("single_cnt", {16'b0, beat_cnt}, 32'h1);
    check("single_err", {31'b0, err_lsb}, 32'h0);
    cycle(0, 0, 1, 0, 0);

    // Streaming after a fresh reset
    cycle(0, 0, 1, 0, 1);
    for (int k = 1; k <= 8; k++) cycle(1, 32'(4 * k), 1, 0, 0);
    check("stream_last", i0_data, 32'h8);
    check("stream_cnt", {16'b0, beat_cnt}, 32'h8);
    cycle(0, 0, 1, 0, 0);

    // Backpressure fills the skid
    cycle(1, 32'h40, 0, 0, 0);
    cycle(1, 32'h80, 0, 0, 0);
    #1;
    check("bp_ready", {31'b0, t0_ready}, 32'h0);
    check("bp_data", i0_data, 32'h10);
    cycle(1, 32'hC0, 0, 0, 0);
    check("bp_hold", i0_data, 32'h10);
    cycle(1, 32'hC0, 1, 0, 0);
    check("bp_second", i0_data, 32'h20);
    cycle(1, 32'hC0, 1, 0, 0);
    check("bp_third", i0_data, 32'h30);
    cycle(0, 0, 1, 0, 0);

    // Error flag
    cycle(1, 32'h13, 1, 0, 0);
    check("err_data", i0_data, 32'h4);
    check("err_set", {31'b0, err_lsb}, 32'h1);
    cycle(1, 32'h1, 1, 1, 0);
    check("err_set_beats_clr", {31'b0, err_lsb}, 32'h1);
    cycle(0, 0, 1, 1, 0);
    check("err_cleared", {31'b0, err_lsb}, 32'h0);

    // Reset mid-operation from the full state
    cycle(1, 32'h101, 0, 0, 0);
    cycle(1, 32'h200, 0, 0, 0);
    cycle(1, 32'h300, 0, 0, 1);
    check("midrst_valid", {31'b0, i0_valid}, 32'h0);
    check("midrst_data", i0_data, 32'h0);
    check("midrst_cnt", {16'b0, beat_cnt}, 32'h0);
    check("midrst_err", {31'b0, err_lsb}, 32'h0);
    cycle(1, 32'h44, 1, 0, 0);
    check("midrst_after", i0_data, 32'h11);
    cycle(0, 0, 1, 0, 0);

    // Saturation of the narrow counter
    cycle(0, 0, 1, 0, 1);
    for (int k = 1; k <= 20; k++) cycle(1, 32'(k << 2), 1, 0, 0);
    check("sat_small", {28'b0, s_beat_cnt}, 32'd15);
    check("sat_wide", {16'b0, beat_cnt}, 32'd20);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end
    cycle(0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
